uart_word_transmitter: RTL and testbench

- Transmit-side counterpart of the UART receive path: accepts one 16-bit word over a valid/ready handshake and serialises it as two back-to-back 8N1 UART frames on `tx`.
- Low byte is sent first, then high byte. This matches the receive-side byte assembly, so a loopback `tx`→`rx` reproduces the word on `r_data`.
- Contains its own oversampling tick generator (16 ticks per bit), a byte sequencer and a bit-level shift FSM.
- Sits between the host/DNN result logic and the board UART pin.

---
 rtl/uart_word_transmitter.sv | 165 ++++++++++++++++
 tb/tb_uart_word_transmitter.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_word_transmitter.sv
// uart_word_transmitter
//
// Serialises one 16-bit word as two back-to-back 8N1 UART frames, low byte
// first, so a receiver that assembles {second byte, first byte} gets the
// original word back. Bit timing comes from an internal oversampling tick
// (16 ticks per bit, CLKS_PER_TICK clocks per tick).
//
// Ports:
//   clk       system clock
//   rst_n     asynchronous active-low reset (aborts any frame, line goes idle)
//   in_data   16-bit word, sampled only on the accept edge
//   in_valid  word available
//   in_ready  idle and able to accept (accept = in_valid && in_ready)
//   tx        registered serial line, idle high
//   busy      high from the accept edge until the done edge
//   done_tick one-cycle pulse in the cycle whose closing edge ends the
//             final stop bit of the high byte
module uart_word_transmitter #(
  parameter int CLKS_PER_TICK = 163,
  parameter int SB_TICK       = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        tx,
  output logic        busy,
  output logic        done_tick
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  localparam logic [15:0] TICK_LAST = 16'(CLKS_PER_TICK - 1);
  localparam logic [4:0]  SB_LAST   = 5'(SB_TICK - 1);

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [4:0]  s_q, s_d;
  logic [2:0]  n_q, n_d;
  logic [7:0]  b_q, b_d;
  logic        byte_sel_q, byte_sel_d;
  // Only the high byte of the word needs to be kept: the low byte goes
  // straight into the shift register on the accept edge.
  logic [7:0]  w_hi_q, w_hi_d;
  logic        tx_q, tx_d;
  logic        tick;
  logic        done_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      s_q        <= '0;
      n_q        <= '0;
      b_q        <= '0;
      byte_sel_q <= 1'b0;
      w_hi_q     <= '0;
      tx_q       <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      s_q        <= s_d;
      n_q        <= n_d;
      b_q        <= b_d;
      byte_sel_q <= byte_sel_d;
      w_hi_q     <= w_hi_d;
      tx_q       <= tx_d;
    end
  end

  // Tick generator: parked at 0 while idle so every word starts with a
  // full-length first tick measured from the accept edge.
  always_comb begin
    tick  = (state_q != IDLE) && (cnt_q == TICK_LAST);
    cnt_d = cnt_q + 16'd1;
    if (state_q == IDLE || tick) begin
      cnt_d = '0;
    end
  end

  // tx is registered, so each transition loads the level of the next
  // segment on the same edge that changes state.
  always_comb begin
    state_d    = state_q;
    s_d        = s_q;
    n_d        = n_q;
    b_d        = b_q;
    byte_sel_d = byte_sel_q;
    w_hi_d     = w_hi_q;
    tx_d       = tx_q;
    done_c     = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          w_hi_d     = in_data[15:8];
          b_d        = in_data[7:0];
          byte_sel_d = 1'b0;
          s_d        = '0;
          state_d    = START;
          tx_d       = 1'b0;
        end
      end
      START: begin
        if (tick) begin
          if (s_q == 5'd15) begin
            s_d     = '0;
            n_d     = '0;
            state_d = DATA;
            tx_d    = b_q[0];
          end else begin
            s_d = s_q + 5'd1;
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (s_q == 5'd15) begin
            s_d = '0;
            b_d = {1'b0, b_q[7:1]};
            if (n_q == 3'd7) begin
              state_d = STOP;
              tx_d    = 1'b1;
            end else begin
              n_d  = n_q + 3'd1;
              tx_d = b_q[1];
            end
          end else begin
            s_d = s_q + 5'd1;
          end
        end
      end
      STOP: begin
        if (tick) begin
          if (s_q == SB_LAST) begin
            s_d = '0;
            if (!byte_sel_q) begin
              // Straight into the high byte's start bit, no idle gap.
              byte_sel_d = 1'b1;
              b_d        = w_hi_q;
              state_d    = START;
              tx_d       = 1'b0;
            end else begin
              state_d = IDLE;
              done_c  = 1'b1;
              tx_d    = 1'b1;
            end
          end else begin
            s_d = s_q + 5'd1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  assign tx        = tx_q;
  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign done_tick = done_c;

endmodule

// File: tb/tb_uart_word_transmitter.sv
module tb_uart_word_transmitter;

  localparam int CPT1 = 2;
  localparam int SB1  = 16;
  localparam int CPT2 = 1;
  localparam int SB2  = 32;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [15:0] in_data1, in_data2;
  logic        in_valid1, in_valid2;
  logic        in_ready1, in_ready2;
  logic        tx1, tx2, busy1, busy2, done1, done2;

  uart_word_transmitter #(.CLKS_PER_TICK(CPT1), .SB_TICK(SB1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data1), .in_valid(in_valid1),
    .in_ready(in_ready1), .tx(tx1), .busy(busy1), .done_tick(done1)
  );

  uart_word_transmitter #(.CLKS_PER_TICK(CPT2), .SB_TICK(SB2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data2), .in_valid(in_valid2),
    .in_ready(in_ready2), .tx(tx2), .busy(busy2), .done_tick(done2)
  );

  int checks = 0;
  int failures = 0;

  logic wv [0:1023];
  logic dn [0:1023];
  logic rd [0:1023];
  logic bs [0:1023];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected line level in cycle c (1 = first cycle after the accept edge).
  function automatic logic exp_tx(input logic [15:0] w, input int c, input int p, input int s);
    int f;
    int r;
    int k;
    logic [7:0] by;
    f = 9 * p + s;
    if (c < 1 || c > 2 * f) return 1'b1;
    r  = (c - 1) % f;
    by = ((c - 1) / f != 0) ? w[15:8] : w[7:0];
    k  = r / p;
    if (k == 0) return 1'b0;
    if (k <= 8) return by[k-1];
    return 1'b1;
  endfunction

  task automatic set_in(input int sel, input logic v, input logic [15:0] d);
    if (sel == 0) begin
      in_valid1 = v;
      in_data1  = d;
    end else begin
      in_valid2 = v;
      in_data2  = d;
    end
  endtask

  task automatic send(input int sel, input logic [15:0] w);
    int guard;
    logic r;
    guard = 0;
    @(negedge clk);
    r = (sel == 0) ? in_ready1 : in_ready2;
    while (!r && guard < 5000) begin
      @(negedge clk);
      r = (sel == 0) ? in_ready1 : in_ready2;
      guard++;
    end
    check_eq("send_ready", r, 1);
    set_in(sel, 1'b1, w);
    @(posedge clk);
  endtask

  task automatic capture(input int sel, input int n, input bit hold,
                         input int inj_c, input logic [15:0] inj_w);
    for (int c = 1; c <= n; c++) begin
      @(negedge clk);
      if (c == 1 && !hold) set_in(sel, 1'b0, (sel == 0) ? in_data1 : in_data2);
      if (sel == 0) begin
        wv[c] = tx1; dn[c] = done1; rd[c] = in_ready1; bs[c] = busy1;
      end else begin
        wv[c] = tx2; dn[c] = done2; rd[c] = in_ready2; bs[c] = busy2;
      end
      if (inj_c != 0 && c == inj_c) set_in(sel, 1'b1, inj_w);
      if (!hold && inj_c != 0 && c == inj_c + 1)
        set_in(sel, 1'b0, (sel == 0) ? in_data1 : in_data2);
    end
  endtask

  task automatic check_word(input string tag, input logic [15:0] w, input int p, input int s);
    int f;
    int txe;
    int dne;
    int hse;
    int fre;
    logic [15:0] got;
    f = 9 * p + s;
    txe = 0; dne = 0; hse = 0; fre = 0;
    for (int c = 1; c <= 2 * f; c++) begin
      if (wv[c] !== exp_tx(w, c, p, s)) txe++;
      if (dn[c] !== (c == 2 * f)) dne++;
      if (rd[c] !== 1'b0 || bs[c] !== 1'b1) hse++;
    end
    got = '0;
    for (int fr = 0; fr < 2; fr++) begin
      if (wv[fr * f + p / 2] !== 1'b0) fre++;
      for (int i = 0; i < 8; i++) got[fr * 8 + i] = wv[fr * f + (i + 1) * p + p / 2];
      if (wv[fr * f + 9 * p + s / 2] !== 1'b1) fre++;
    end
    check_eq({tag, "_tx_wave_errs"}, txe, 0);
    check_eq({tag, "_done_errs"}, dne, 0);
    check_eq({tag, "_ready_busy_errs"}, hse, 0);
    check_eq({tag, "_framing_errs"}, fre, 0);
    check_eq({tag, "_rx_word"}, got, w);
  endtask

  initial begin
    logic [15:0] lb [4];
    int e;
    int d;
    lb[0] = 16'h0000; lb[1] = 16'hFFFF; lb[2] = 16'h1234; lb[3] = 16'h8001;

    // Reset, with a request pending that must not be taken.
    rst_n = 1'b0;
    in_valid1 = 1'b1; in_data1 = 16'h5555;
    in_valid2 = 1'b0; in_data2 = 16'h0000;
    repeat (3) @(negedge clk);
    check_eq("rst_tx", tx1, 1);
    check_eq("rst_in_ready", in_ready1, 1);
    check_eq("rst_busy", busy1, 0);
    check_eq("rst_done", done1, 0);
    check_eq("rst_tx2", tx2, 1);
    in_valid1 = 1'b0;
    rst_n = 1'b1;
    capture(0, 40, 1, 0, 16'h0);
    e = 0;
    for (int c = 1; c <= 40; c++) if (wv[c] !== 1'b1 || bs[c] !== 1'b0) e++;
    check_eq("reset_wins_idle_errs", e, 0);

    // Single word A55A
    send(0, 16'hA55A);
    capture(0, 650, 0, 0, 16'h0);
    check_word("a55a", 16'hA55A, 16 * CPT1, SB1 * CPT1);
    check_eq("a55a_tx_c1", wv[1], 0);
    check_eq("a55a_tx_c32", wv[32], 0);
    check_eq("a55a_bit0", wv[33], 0);
    check_eq("a55a_bit1", wv[65], 1);
    check_eq("a55a_hi_start", wv[321], 0);
    check_eq("a55a_done_c639", dn[639], 0);
    check_eq("a55a_done_c640", dn[640], 1);
    e = 0;
    for (int c = 641; c <= 650; c++) if (wv[c] !== 1'b1 || rd[c] !== 1'b1 || bs[c] !== 1'b0) e++;
    check_eq("a55a_after_idle_errs", e, 0);

    // Loopback-style decode of several words
    foreach (lb[i]) begin
      send(0, lb[i]);
      capture(0, 641, 0, 0, 16'h0);
      check_word($sformatf("word%0d", i), lb[i], 16 * CPT1, SB1 * CPT1);
    end

    // Request while busy is ignored
    send(0, 16'h3C96);
    capture(0, 700, 0, 100, 16'hBEEF);
    check_word("busy_ign", 16'h3C96, 16 * CPT1, SB1 * CPT1);
    e = 0;
    for (int c = 641; c <= 700; c++) if (wv[c] !== 1'b1 || bs[c] !== 1'b0) e++;
    check_eq("busy_ign_no_queue_errs", e, 0);

    // Back-to-back with in_valid held high
    send(0, 16'h1357);
    capture(0, 641, 1, 1, 16'h9BDF);
    check_word("b2b_w1", 16'h1357, 16 * CPT1, SB1 * CPT1);
    check_eq("b2b_gap_tx", wv[641], 1);
    check_eq("b2b_gap_ready", rd[641], 1);
    capture(0, 641, 0, 0, 16'h0);
    check_eq("b2b_start_next", wv[1], 0);
    check_word("b2b_w2", 16'h9BDF, 16 * CPT1, SB1 * CPT1);

    // Reset in the middle of the low byte's data bits
    send(0, 16'hA55A);
    capture(0, 100, 0, 0, 16'h0);
    #2 rst_n = 1'b0;
    #1;
    check_eq("midrst_tx", tx1, 1);
    check_eq("midrst_in_ready", in_ready1, 1);
    check_eq("midrst_busy", busy1, 0);
    @(negedge clk);
    rst_n = 1'b1;
    e = 0; d = 0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      if (done1 !== 1'b0) d++;
      if (tx1 !== 1'b1 || busy1 !== 1'b0) e++;
    end
    check_eq("midrst_no_done", d, 0);
    check_eq("midrst_idle_errs", e, 0);

    // CLKS_PER_TICK=1, SB_TICK=32
    send(1, 16'hC3A5);
    capture(1, 360, 0, 0, 16'h0);
    check_word("corner", 16'hC3A5, 16 * CPT2, SB2 * CPT2);
    check_eq("corner_done_352", dn[352], 1);
    e = 0;
    for (int c = 145; c <= 176; c++) if (wv[c] !== 1'b1) e++;
    check_eq("corner_stop_len_errs", e, 0);
    check_eq("corner_hi_start", wv[177], 0);
    check_eq("corner_idle_ready", rd[353], 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
